gate_result_checker: RTL and testbench

Self-checking consumer that sits directly downstream of the two-input basic-gate dataflow block. Each cycle it can accept one sample: the operands `a`, `b` and the seven gate outputs. It compares the outputs against a golden truth table and keeps pass/fail statistics, operand-combination coverage and a record of the first failure. Benches and on-board self-test instantiate it alongside the gate block in place of manual `$display` inspection.

---
 rtl/gate_result_checker.sv | 148 ++++++++++++++
 tb/tb_gate_result_checker.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_result_checker.sv
// gate_result_checker
//
// Self-checking consumer for the two-input basic-gate block. Each accepted
// sample (operands plus seven gate outputs) is registered in S1. On the next
// edge S2 compares it against the golden truth table and updates the result
// outputs and the statistics.
//
// Optional feature: define GATE_CHK_FIRST_FAIL_EN to build the first-failure
// capture registers. When it is undefined, first_fail_ab and first_fail_vec
// are tied to 0.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   clr               synchronous statistics clear (also flushes the pipeline)
//   in_valid          sample strobe (always ready)
//   a, b              operands fed to the gate block
//   out_*             the seven gate block outputs
//   chk_valid         one-cycle pulse, check result presented
//   chk_pass          all outputs matched (qualified by chk_valid)
//   mismatch[6:0]     per-gate mismatch bits: and,or,not,nand,nor,xor,xnor
//   sample_cnt        samples checked (saturating)
//   error_cnt         samples failed (saturating)
//   coverage[3:0]     bit {a,b} set once that combination was checked
//   all_covered       &coverage
//   sticky_err        any failure since rst/clr
//   first_fail_ab     {a,b} of the first failing sample
//   first_fail_vec    mismatch of the first failing sample
module gate_result_checker #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             out_and,
    input  logic             out_or,
    input  logic             out_not,
    input  logic             out_nand,
    input  logic             out_nor,
    input  logic             out_xor,
    input  logic             out_xnor,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic [6:0]       mismatch,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] error_cnt,
    output logic [3:0]       coverage,
    output logic             all_covered,
    output logic             sticky_err,
    output logic [1:0]       first_fail_ab,
    output logic [6:0]       first_fail_vec
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    // S1 registers
    logic       s1_valid;
    logic       s1_a;
    logic       s1_b;
    logic [6:0] s1_obs;

    // S2 combinational compare
    logic [6:0] expected;
    logic [6:0] cur_mm;
    logic       cur_fail;

    always_comb begin
        expected    = 7'b0;
        expected[0] = s1_a & s1_b;
        expected[1] = s1_a | s1_b;
        expected[2] = ~s1_a;
        expected[3] = ~(s1_a & s1_b);
        expected[4] = ~(s1_a | s1_b);
        expected[5] = s1_a ^ s1_b;
        expected[6] = ~(s1_a ^ s1_b);
        cur_mm      = s1_obs ^ expected;
        cur_fail    = |cur_mm;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a       <= 1'b0;
            s1_b       <= 1'b0;
            s1_obs     <= 7'b0;
            chk_valid  <= 1'b0;
            chk_pass   <= 1'b0;
            mismatch   <= 7'b0;
            sample_cnt <= '0;
            error_cnt  <= '0;
            coverage   <= 4'b0;
            sticky_err <= 1'b0;
        end else if (clr) begin
            // Result outputs chk_pass/mismatch are held; only rst zeroes them.
            s1_valid   <= 1'b0;
            chk_valid  <= 1'b0;
            sample_cnt <= '0;
            error_cnt  <= '0;
            coverage   <= 4'b0;
            sticky_err <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a   <= a;
                s1_b   <= b;
                s1_obs <= {out_xnor, out_xor, out_nor, out_nand, out_not, out_or, out_and};
            end

            chk_valid <= s1_valid;
            if (s1_valid) begin
                mismatch <= cur_mm;
                chk_pass <= ~cur_fail;
                if (sample_cnt != CntMax) begin
                    sample_cnt <= sample_cnt + CntOne;
                end
                if (cur_fail && (error_cnt != CntMax)) begin
                    error_cnt <= error_cnt + CntOne;
                end
                coverage[{s1_a, s1_b}] <= 1'b1;
                if (cur_fail) begin
                    sticky_err <= 1'b1;
                end
            end
        end
    end

    assign all_covered = &coverage;

`ifdef GATE_CHK_FIRST_FAIL_EN
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            first_fail_ab  <= 2'b0;
            first_fail_vec <= 7'b0;
        end else if (s1_valid && cur_fail && !sticky_err) begin
            // Loads on the same edge that sets sticky_err; later failures are ignored.
            first_fail_ab  <= {s1_a, s1_b};
            first_fail_vec <= cur_mm;
        end
    end
`else
    assign first_fail_ab  = 2'b0;
    assign first_fail_vec = 7'b0;
`endif

endmodule

// File: tb/tb_gate_result_checker.sv
module tb_gate_result_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic [6:0] obs = 7'b0;

    always #5 clk = ~clk;

    // Default-width instance
    logic       w8_cv, w8_pass, w8_all, w8_sticky;
    logic [6:0] w8_mm, w8_ffvec;
    logic [7:0] w8_cnt, w8_err;
    logic [3:0] w8_cov;
    logic [1:0] w8_ffab;

    // Narrow instance for saturation
    logic       w2_cv, w2_pass, w2_all, w2_sticky;
    logic [6:0] w2_mm, w2_ffvec;
    logic [1:0] w2_cnt, w2_err;
    logic [3:0] w2_cov;
    logic [1:0] w2_ffab;

    gate_result_checker dut8 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .a(a), .b(b),
        .out_and(obs[0]), .out_or(obs[1]), .out_not(obs[2]), .out_nand(obs[3]),
        .out_nor(obs[4]), .out_xor(obs[5]), .out_xnor(obs[6]),
        .chk_valid(w8_cv), .chk_pass(w8_pass), .mismatch(w8_mm),
        .sample_cnt(w8_cnt), .error_cnt(w8_err), .coverage(w8_cov),
        .all_covered(w8_all), .sticky_err(w8_sticky),
        .first_fail_ab(w8_ffab), .first_fail_vec(w8_ffvec)
    );

    gate_result_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .a(a), .b(b),
        .out_and(obs[0]), .out_or(obs[1]), .out_not(obs[2]), .out_nand(obs[3]),
        .out_nor(obs[4]), .out_xor(obs[5]), .out_xnor(obs[6]),
        .chk_valid(w2_cv), .chk_pass(w2_pass), .mismatch(w2_mm),
        .sample_cnt(w2_cnt), .error_cnt(w2_err), .coverage(w2_cov),
        .all_covered(w2_all), .sticky_err(w2_sticky),
        .first_fail_ab(w2_ffab), .first_fail_vec(w2_ffvec)
    );

    int n_vec = 0;
    int n_bad = 0;
    int p8 = 0;
    int p2 = 0;

    // Truth table, bits {xnor,xor,nor,nand,not,or,and}
    function automatic logic [6:0] golden(input logic [1:0] ab);
        case (ab)
            2'b00:   return 7'b1011100;
            2'b01:   return 7'b0101110;
            2'b10:   return 7'b0101010;
            default: return 7'b1000011;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one in-flight sample, results one edge later.
    logic       m_cv, m_pass, m_sticky;
    logic [6:0] m_mm, m_ffvec;
    logic [3:0] m_cov;
    logic [1:0] m_ffab;
    int         m_cnt8, m_err8, m_cnt2, m_err2;
    logic       pend_v;
    logic [1:0] pend_ab;
    logic [6:0] pend_obs;

    function automatic int sat_inc(input int v, input int max);
        return (v < max) ? v + 1 : v;
    endfunction

    task automatic model_step();
        logic [6:0] mm;
        if (rst) begin
            m_cv = 0; m_pass = 0; m_mm = 0; m_sticky = 0; m_ffab = 0; m_ffvec = 0;
            m_cov = 0; m_cnt8 = 0; m_err8 = 0; m_cnt2 = 0; m_err2 = 0; pend_v = 0;
        end else if (clr) begin
            m_cv = 0; m_sticky = 0; m_ffab = 0; m_ffvec = 0;
            m_cov = 0; m_cnt8 = 0; m_err8 = 0; m_cnt2 = 0; m_err2 = 0; pend_v = 0;
        end else begin
            m_cv = pend_v;
            if (pend_v) begin
                mm     = pend_obs ^ golden(pend_ab);
                m_mm   = mm;
                m_pass = (mm == 7'b0);
                m_cnt8 = sat_inc(m_cnt8, 255);
                m_cnt2 = sat_inc(m_cnt2, 3);
                if (mm != 7'b0) begin
                    m_err8 = sat_inc(m_err8, 255);
                    m_err2 = sat_inc(m_err2, 3);
                    if (!m_sticky) begin
                        m_ffab  = pend_ab;
                        m_ffvec = mm;
                    end
                    m_sticky = 1;
                end
                m_cov[pend_ab] = 1'b1;
            end
            pend_v   = in_valid;
            pend_ab  = {a, b};
            pend_obs = obs;
        end
    endtask

    task automatic compare_all();
        logic [1:0] e_ffab;
        logic [6:0] e_ffvec;
`ifdef GATE_CHK_FIRST_FAIL_EN
        e_ffab  = m_ffab;
        e_ffvec = m_ffvec;
`else
        e_ffab  = 2'b0;
        e_ffvec = 7'b0;
`endif
        check("chk_valid8", w8_cv, m_cv);
        check("chk_pass8", w8_pass, m_pass);
        check("mismatch8", w8_mm, m_mm);
        check("sample_cnt8", w8_cnt, m_cnt8);
        check("error_cnt8", w8_err, m_err8);
        check("coverage8", w8_cov, m_cov);
        check("all_covered8", w8_all, &m_cov);
        check("sticky8", w8_sticky, m_sticky);
        check("ff_ab8", w8_ffab, e_ffab);
        check("ff_vec8", w8_ffvec, e_ffvec);
        check("chk_valid2", w2_cv, m_cv);
        check("chk_pass2", w2_pass, m_pass);
        check("mismatch2", w2_mm, m_mm);
        check("sample_cnt2", w2_cnt, m_cnt2);
        check("error_cnt2", w2_err, m_err2);
        check("coverage2", w2_cov, m_cov);
        check("sticky2", w2_sticky, m_sticky);
        check("ff_ab2", w2_ffab, e_ffab);
        check("ff_vec2", w2_ffvec, e_ffvec);
        if (w8_cv === 1'b1) p8++;
        if (w2_cv === 1'b1) p2++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_all();
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [1:0] ab, input logic [6:0] fault);
        in_valid = 1'b1;
        {a, b}   = ab;
        obs      = golden(ab) ^ fault;
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    int base8, base2;
    logic [1:0] exp_ffab;
    logic [6:0] exp_ffvec;

    initial begin
        repeat (2) step();
        rst = 1'b0;
        check("lit_reset_cnt", w8_cnt, 0);
        check("lit_reset_all", w8_all, 0);
        check("lit_reset_mm", w8_mm, 0);

        // Four passing combinations back-to-back
        send(2'b00, 7'b0);
        send(2'b01, 7'b0);
        send(2'b10, 7'b0);
        send(2'b11, 7'b0);
        idle(2);
        check("lit_cnt4", w8_cnt, 4);
        check("lit_err0", w8_err, 0);
        check("lit_cov", w8_cov, 4'b1111);
        check("lit_allcov", w8_all, 1);
        check("lit_pulses4", p8, 4);

`ifdef GATE_CHK_FIRST_FAIL_EN
        exp_ffab = 2'b10; exp_ffvec = 7'b0100000;
`else
        exp_ffab = 2'b00; exp_ffvec = 7'b0000000;
`endif
        // xor fault with a=1,b=0
        send(2'b10, 7'b0100000);
        idle(1);
        check("lit_xor_valid", w8_cv, 1);
        check("lit_xor_pass", w8_pass, 0);
        check("lit_xor_mm", w8_mm, 7'b0100000);
        check("lit_xor_sticky", w8_sticky, 1);
        check("lit_xor_ffab", w8_ffab, exp_ffab);
        check("lit_xor_ffvec", w8_ffvec, exp_ffvec);

        // Second fault on not with {a,b}=00
        send(2'b00, 7'b0000100);
        idle(1);
        check("lit_not_mm", w8_mm, 7'b0000100);
        check("lit_err2", w8_err, 2);
        check("lit_ffab_kept", w8_ffab, exp_ffab);
        check("lit_ffvec_kept", w8_ffvec, exp_ffvec);
        idle(1);

        // Saturation on the narrow instance
        clr = 1'b1;
        step();
        clr = 1'b0;
        base2 = p2;
        send(2'b00, 7'b0);
        send(2'b01, 7'b0);
        send(2'b10, 7'b0);
        send(2'b11, 7'b0);
        send(2'b00, 7'b0);
        idle(2);
        check("lit_sat_cnt", w2_cnt, 3);
        check("lit_sat_pulses", p2 - base2, 5);
        send(2'b11, 7'b0000001);
        idle(2);
        check("lit_sat_cnt_hold", w2_cnt, 3);
        check("lit_sat_err", w2_err, 1);
        check("lit_sat_mm", w2_mm, 7'b0000001);
        check("lit_cnt8_6", w8_cnt, 6);

        // clr the cycle after in_valid
        base8 = p8;
        send(2'b01, 7'b0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        idle(3);
        check("lit_clr_nopulse", p8 - base8, 0);
        check("lit_clr_cnt", w8_cnt, 0);
        check("lit_clr_err", w8_err, 0);
        check("lit_clr_cov", w8_cov, 0);
        check("lit_clr_sticky", w8_sticky, 0);
        check("lit_clr_ffvec", w8_ffvec, 0);

        // Sample in the same cycle as clr is dropped
        in_valid = 1'b1; {a, b} = 2'b11; obs = golden(2'b11) ^ 7'b1000000;
        clr = 1'b1;
        step();
        clr = 1'b0;
        idle(3);
        check("lit_clr_same_nopulse", p8 - base8, 0);
        check("lit_clr_same_cnt", w8_cnt, 0);

        // rst the cycle after in_valid, with a held nonzero mismatch
        send(2'b00, 7'h7f);
        idle(2);
        check("lit_pre_rst_mm", w8_mm, 7'h7f);
        base8 = p8;
        send(2'b01, 7'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(3);
        check("lit_rst_nopulse", p8 - base8, 0);
        check("lit_rst_mm", w8_mm, 0);
        check("lit_rst_pass", w8_pass, 0);
        check("lit_rst_cnt", w8_cnt, 0);

        // Idle stability
        send(2'b10, 7'b0);
        send(2'b01, 7'b0);
        idle(2);
        base8 = p8;
        idle(10);
        check("lit_idle_nopulse", p8 - base8, 0);
        check("lit_idle_cnt", w8_cnt, 2);
        check("lit_idle_cov", w8_cov, 4'b0110);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
